// File: rtl/mul_div_unit.sv
// E-stage multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU run for a fixed latency and write HI/LO when the countdown ends;
// MTHI/MTLO write immediately, MFHI/MFLO are pure reads through md_out.
// Optional build macro MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU (64-bit accumulate on HI/LO).
module mul_div_unit #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
    localparam logic [3:0] OpMfhi  = 4'd7;
    localparam logic [3:0] OpMflo  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OpMadd  = 4'd9;
    localparam logic [3:0] OpMaddu = 4'd10;
    localparam logic [3:0] OpMsub  = 4'd11;
    localparam logic [3:0] OpMsubu = 4'd12;
`endif

    localparam logic [3:0] MulCnt = 4'(MUL_CYCLES);
    localparam logic [3:0] DivCnt = 4'(DIV_CYCLES);

    logic        busy_q, busy_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_n_q, hi_n_d;
    logic [31:0] lo_n_q, lo_n_d;

    logic        issue;
    logic        mul_signed;
    logic [63:0] a_ext, b_ext, product;
    logic        div_signed, rs_neg, rt_neg;
    logic [31:0] a_mag, b_mag, b_safe, uq, ur, quot, rem;
`ifdef MDU_MADD_EN
    logic [63:0] acc;
`endif

    // Operand conditioning and the raw multiply/divide datapath.
    always_comb begin
        issue      = start & ~req & ~busy_q;
`ifdef MDU_MADD_EN
        mul_signed = (op == OpMult) || (op == OpMadd) || (op == OpMsub);
`else
        mul_signed = (op == OpMult);
`endif
        a_ext      = {{32{mul_signed & rs_val[31]}}, rs_val};
        b_ext      = {{32{mul_signed & rt_val[31]}}, rt_val};
        product    = a_ext * b_ext;

        // Divide on magnitudes so that 0x80000000 / -1 wraps cleanly to 0x80000000.
        div_signed = (op == OpDiv);
        rs_neg     = div_signed & rs_val[31];
        rt_neg     = div_signed & rt_val[31];
        a_mag      = rs_neg ? (~rs_val + 32'd1) : rs_val;
        b_mag      = rt_neg ? (~rt_val + 32'd1) : rt_val;
        b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
        uq         = a_mag / b_safe;
        ur         = a_mag % b_safe;
        quot       = (rs_neg ^ rt_neg) ? (~uq + 32'd1) : uq;
        rem        = rs_neg ? (~ur + 32'd1) : ur;
`ifdef MDU_MADD_EN
        acc        = {hi_q, lo_q};
`endif
    end

    // Next-state: countdown while busy, otherwise decode an accepted operation.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        hi_n_d = hi_n_q;
        lo_n_d = lo_n_q;
        if (busy_q) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                hi_d   = hi_n_q;
                lo_d   = lo_n_q;
                busy_d = 1'b0;
            end
        end else if (issue) begin
            case (op)
                OpMult, OpMultu: begin
                    {hi_n_d, lo_n_d} = product;
                    cnt_d            = MulCnt;
                    busy_d           = 1'b1;
                end
                OpDiv, OpDivu: begin
                    // Divide by zero still runs the full sequence but writes HI/LO back unchanged.
                    if (rt_val == 32'd0) begin
                        hi_n_d = hi_q;
                        lo_n_d = lo_q;
                    end else begin
                        hi_n_d = rem;
                        lo_n_d = quot;
                    end
                    cnt_d  = DivCnt;
                    busy_d = 1'b1;
                end
`ifdef MDU_MADD_EN
                OpMadd, OpMaddu: begin
                    {hi_n_d, lo_n_d} = acc + product;
                    cnt_d            = MulCnt;
                    busy_d           = 1'b1;
                end
                OpMsub, OpMsubu: begin
                    {hi_n_d, lo_n_d} = acc - product;
                    cnt_d            = MulCnt;
                    busy_d           = 1'b1;
                end
`endif
                OpMthi:  hi_d = rs_val;
                OpMtlo:  lo_d = rs_val;
                default: ;
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= 4'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            hi_n_q <= 32'd0;
            lo_n_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            hi_n_q <= hi_n_d;
            lo_n_q <= lo_n_d;
        end
    end

    // MFHI/MFLO read port; HI/LO only change at the end of an op, so reads while busy see old values.
    always_comb begin
        md_out = 32'd0;
        if (op == OpMfhi) begin
            md_out = hi_q;
        end else if (op == OpMflo) begin
            md_out = lo_q;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
